// File: rtl/seq_left_shift_pkg.sv
// rtl/seq_left_shift_pkg.sv - shared constants and state encoding for the sequential left shifter
//
// Purpose : operand/shift-amount widths and the FSM state type used by the
//           shifter, its interface and the testbench.
// Ports   : none (package).
package seq_left_shift_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_left_shift_if.sv
// rtl/seq_left_shift_if.sv - request/response bundle for the sequential left shifter
//
// Purpose : groups the start/operand request and the ready/result response.
// Signals : start, x, shamt        (master -> slave)
//           ready, result_valid,
//           result, ovf            (slave -> master)
interface seq_left_shift_if #(
    parameter int WIDTH   = seq_left_shift_pkg::WIDTH,
    parameter int SHAMT_W = seq_left_shift_pkg::SHAMT_W
);

    logic               start;
    logic [WIDTH-1:0]   x;
    logic [SHAMT_W-1:0] shamt;
    logic               ready;
    logic               result_valid;
    logic [WIDTH-1:0]   result;
    logic               ovf;

    modport master (
        output start, x, shamt,
        input  ready, result_valid, result, ovf
    );

    modport slave (
        input  start, x, shamt,
        output ready, result_valid, result, ovf
    );

endinterface

// File: rtl/seq_left_shift_left_shift_2.sv
// rtl/seq_left_shift_left_shift_2.sv - fixed 2-bit logical left shift
//
// Purpose : combinational x << 2 with zero fill; the two-position step of the
//           sequential shifter.
// Ports   : i_x [WIDTH-1:0]  operand
//           o_y [WIDTH-1:0]  i_x shifted left by two, o_y[1:0] = 0
module left_shift_2
    import seq_left_shift_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [W-1:0] i_x,
    output logic [W-1:0] o_y
);

    assign o_y = {i_x[W-3:0], 2'b00};

endmodule

// File: rtl/seq_left_shift.sv
// rtl/seq_left_shift.sv - multi-cycle 32-bit logical left shifter with signed overflow flag
//
// Purpose : shifts x left by shamt, retiring two positions per cycle (one on
//           the last odd step), and flags when x * 2^shamt does not fit in
//           32-bit two's complement.
// Ports   : clock  rising-edge clock
//           reset  asynchronous active-low reset
//           bus    seq_left_shift_if.slave (start/x/shamt in,
//                  ready/result_valid/result/ovf out)
module seq_left_shift
    import seq_left_shift_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    seq_left_shift_if.slave   bus
);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_acc;
    logic [SHAMT_W-1:0] r_rem;
    logic               r_ovf;

    logic [WIDTH-1:0]   w_acc_sh2;
    logic               w_ovf_step2;
    logic               w_ovf_step1;

    left_shift_2 #(.W(WIDTH)) u_left_shift_2 (
        .i_x (r_acc),
        .o_y (w_acc_sh2)
    );

    // A step overflows when any bit about to become the sign bit differs
    // from the current sign bit.
    assign w_ovf_step2 = (r_acc[WIDTH-1] != r_acc[WIDTH-2]) ||
                         (r_acc[WIDTH-1] != r_acc[WIDTH-3]);
    assign w_ovf_step1 = (r_acc[WIDTH-1] != r_acc[WIDTH-2]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_next = (bus.shamt != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                // rem is never 0 here; rem of 1 or 2 finishes on this edge.
                if (r_rem <= SHAMT_W'(2)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
            r_rem <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_acc <= bus.x;
                        r_rem <= bus.shamt;
                        r_ovf <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (r_rem >= SHAMT_W'(2)) begin
                        r_acc <= w_acc_sh2;
                        r_rem <= r_rem - SHAMT_W'(2);
                        r_ovf <= r_ovf | w_ovf_step2;
                    end else begin
                        r_acc <= {r_acc[WIDTH-2:0], 1'b0};
                        r_rem <= '0;
                        r_ovf <= r_ovf | w_ovf_step1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.ready        = (r_state == ST_IDLE);
    assign bus.result_valid = (r_state == ST_DONE);
    assign bus.result       = r_acc;
    assign bus.ovf          = r_ovf;

endmodule

// File: tb/tb_seq_left_shift.sv
// tb/tb_seq_left_shift.sv - self-checking bench for seq_left_shift
module tb_seq_left_shift;

    logic clock;
    logic reset;
    int   errors;
    int   checks;

    seq_left_shift_if bus_if ();

    seq_left_shift u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: plain arithmetic on the operand.
    function automatic logic [31:0] model_result(input logic [31:0] x, input int sh);
        return x << sh;
    endfunction

    function automatic logic model_ovf(input logic [31:0] x, input int sh);
        longint p;
        longint lim;
        lim = 64'sh0000_0000_8000_0000;
        p   = longint'($signed(x)) * (longint'(1) << sh);
        return (p >= lim) || (p < -lim);
    endfunction

    // Cycle-level expectation: m_wait < 0 idle, 0 result cycle, > 0 shifting.
    int          m_wait;
    logic [31:0] m_res;
    logic        m_ovf;

    initial begin
        m_wait = -1;
        m_res  = '0;
        m_ovf  = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                m_wait = -1;
                m_res  = '0;
                m_ovf  = 1'b0;
            end
            chk("cmp_ready", {31'd0, bus_if.ready}, {31'd0, m_wait < 0});
            chk("cmp_valid", {31'd0, bus_if.result_valid}, {31'd0, m_wait == 0});
            if (m_wait <= 0) begin
                chk("cmp_result", bus_if.result, m_res);
                chk("cmp_ovf", {31'd0, bus_if.ovf}, {31'd0, m_ovf});
            end
            if (reset) begin
                if (m_wait < 0) begin
                    if (bus_if.start) begin
                        m_res  = model_result(bus_if.x, int'(bus_if.shamt));
                        m_ovf  = model_ovf(bus_if.x, int'(bus_if.shamt));
                        m_wait = (int'(bus_if.shamt) + 1) / 2;
                    end
                end else begin
                    m_wait--;
                end
            end
        end
    end

    // One request; lat counts edges after the accept edge before the result cycle.
    task automatic run_op(input logic [31:0] x, input logic [4:0] sh,
                          input logic [31:0] exp_res, input logic exp_ovf, input int exp_lat);
        int  tries;
        int  lat;
        bit  seen;
        tries = 0;
        @(posedge clock); #1;
        while (!bus_if.ready && tries < 40) begin
            @(posedge clock); #1;
            tries++;
        end
        if (!bus_if.ready) chk("ready_timeout", 32'd0, 32'd1);
        bus_if.start = 1'b1;
        bus_if.x     = x;
        bus_if.shamt = sh;
        @(posedge clock); #1;
        bus_if.start = 1'b0;
        lat  = 0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (bus_if.result_valid) seen = 1;
            else lat++;
        end
        chk("op_valid_seen", {31'd0, seen}, 32'd1);
        chk("op_latency", 32'(lat), 32'(exp_lat));
        chk("op_result", bus_if.result, exp_res);
        chk("op_ovf", {31'd0, bus_if.ovf}, {31'd0, exp_ovf});
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        reset        = 1'b0;
        bus_if.start = 1'b0;
        bus_if.x     = '0;
        bus_if.shamt = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", {31'd0, bus_if.ready}, 32'd1);
        chk("rst_valid", {31'd0, bus_if.result_valid}, 32'd0);
        chk("rst_result", bus_if.result, 32'd0);
        chk("rst_ovf", {31'd0, bus_if.ovf}, 32'd0);
        reset = 1'b1;

        run_op(32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0, 0);
        run_op(32'h0000_000F, 5'd5,  32'h0000_01E0, 1'b0, 3);
        run_op(32'h4000_0000, 5'd1,  32'h8000_0000, 1'b1, 1);
        run_op(32'hC000_0000, 5'd1,  32'h8000_0000, 1'b0, 1);
        run_op(32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 1'b0, 16);
        run_op(32'h1234_5678, 5'd31, 32'h0000_0000, 1'b1, 16);
        run_op(32'h0000_0000, 5'd31, 32'h0000_0000, 1'b0, 16);
        run_op(32'h0001_0000, 5'd14, 32'h4000_0000, 1'b0, 7);
        run_op(32'h0001_0000, 5'd15, 32'h8000_0000, 1'b1, 8);

        // start held high with a new operand every cycle
        @(posedge clock); #1;
        for (int i = 0; i < 40; i++) begin
            bus_if.start = 1'b1;
            bus_if.x     = 32'h0123_4567 ^ (32'h1F1F_0F0F * 32'(i + 1));
            bus_if.shamt = 5'((i * 7) % 32);
            @(posedge clock); #1;
        end
        bus_if.start = 1'b0;
        repeat (20) @(posedge clock);

        // asynchronous reset in the middle of a shift
        #1;
        bus_if.start = 1'b1;
        bus_if.x     = 32'hA5A5_A5A5;
        bus_if.shamt = 5'd20;
        @(posedge clock); #1;
        bus_if.start = 1'b0;
        repeat (4) @(posedge clock);
        #3;
        chk("mid_ready_busy", {31'd0, bus_if.ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("arst_ready", {31'd0, bus_if.ready}, 32'd1);
        chk("arst_valid", {31'd0, bus_if.result_valid}, 32'd0);
        chk("arst_result", bus_if.result, 32'd0);
        chk("arst_ovf", {31'd0, bus_if.ovf}, 32'd0);
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b1;
        run_op(32'h0000_0003, 5'd2, 32'h0000_000C, 1'b0, 1);

        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
